// File: rtl/proc_wait_sched.sv
// proc_wait_sched: two-process wait scheduler. Grants one process at a time,
// loads a wait value selected by that process's command, counts it down and
// reports expiry, abort (flush) or an illegal command.
//
// state | meaning
// IDLE  | no wait active; arbitrate when req is nonzero
// COUNT | wait active; remaining decrements once per cycle
// DONE  | one-cycle expiry state, req ignored
module proc_wait_sched #(
    parameter int PARA = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req,
    input  logic [4:0]      cmd_type_0,
    input  logic [4:0]      cmd_type_1,
    input  logic [PARA-1:0] proc_rel_time_0,
    input  logic [PARA-1:0] proc_rel_time_1,
    input  logic [PARA-1:0] proc_ext_time_0,
    input  logic [PARA-1:0] proc_ext_time_1,
    input  logic [PARA-1:0] event_proc_0,
    input  logic [PARA-1:0] event_proc_1,
    input  logic            flush,
    output logic [1:0]      gnt,
    output logic [1:0]      done,
    output logic            abort,
    output logic            err,
    output logic            busy,
    output logic            cur_id,
    output logic [PARA-1:0] remaining,
    output logic            ckg_en
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [PARA-1:0] ONE  = {{(PARA-1){1'b0}}, 1'b1};
    localparam logic [PARA-1:0] ZERO = '0;

    state_t          state_q, state_d;
    logic [PARA-1:0] remaining_q, remaining_d;
    logic            cur_id_q, cur_id_d;
    logic            last_q, last_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      done_q, done_d;
    logic            abort_q, abort_d;
    logic            err_q, err_d;
    logic [PARA-1:0] ev0_q, ev0_d;
    logic [PARA-1:0] ev1_q, ev1_d;

    logic            win_id;
    logic [4:0]      win_cmd;
    logic [PARA-1:0] win_n;
    logic            win_illegal;

    // Event reference registers: plain one-cycle delay of the event inputs
    always_comb begin
        ev0_d = event_proc_0;
        ev1_d = event_proc_1;
    end

    // Arbitration and wait-value selection; under contention the process
    // not granted last wins
    always_comb begin
        win_id      = 1'b0;
        win_cmd     = 5'd0;
        win_n       = ZERO;
        win_illegal = 1'b0;
        if (req == 2'b11) begin
            win_id = ~last_q;
        end else begin
            win_id = req[1];
        end
        win_cmd = win_id ? cmd_type_1 : cmd_type_0;
        case (win_cmd)
            5'd1:    win_n = win_id ? proc_rel_time_1 : proc_rel_time_0;
            5'd2:    win_n = win_id ? proc_ext_time_1 : proc_ext_time_0;
            5'd3:    win_n = win_id ? ev1_q : ev0_q;
            default: begin
                win_n       = ZERO;
                win_illegal = 1'b1;
            end
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cur_id_d    = cur_id_q;
        last_d      = last_q;
        gnt_d       = 2'b00;
        done_d      = 2'b00;
        abort_d     = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    cur_id_d       = win_id;
                    last_d         = win_id;
                    gnt_d[win_id]  = 1'b1;
                    err_d          = win_illegal;
                    remaining_d    = win_n;
                    if (win_n == ZERO) begin
                        state_d        = DONE;
                        done_d[win_id] = 1'b1;
                    end else begin
                        state_d = COUNT;
                    end
                end
            end
            COUNT: begin
                if (flush) begin
                    state_d     = IDLE;
                    remaining_d = ZERO;
                    abort_d     = 1'b1;
                end else if (remaining_q <= ONE) begin
                    state_d          = DONE;
                    remaining_d      = ZERO;
                    done_d[cur_id_q] = 1'b1;
                end else begin
                    remaining_d = remaining_q - ONE;
                end
            end
            DONE: begin
                state_d     = IDLE;
                remaining_d = ZERO;
                abort_d     = flush;
            end
            default: begin
                state_d     = IDLE;
                remaining_d = ZERO;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= ZERO;
            cur_id_q    <= 1'b0;
            last_q      <= 1'b1;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            abort_q     <= 1'b0;
            err_q       <= 1'b0;
            ev0_q       <= ZERO;
            ev1_q       <= ZERO;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cur_id_q    <= cur_id_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            err_q       <= err_d;
            ev0_q       <= ev0_d;
            ev1_q       <= ev1_d;
        end
    end

    // Output decode; busy and ckg_en follow the state directly
    always_comb begin
        gnt       = gnt_q;
        done      = done_q;
        abort     = abort_q;
        err       = err_q;
        cur_id    = cur_id_q;
        remaining = remaining_q;
        busy      = (state_q != IDLE);
        ckg_en    = (state_q != COUNT);
    end

endmodule

// File: tb/tb_proc_wait_sched.sv
// Directed bench for proc_wait_sched with hand-computed expected values.
module tb_proc_wait_sched;

    localparam int PARA = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req;
    logic [4:0]      cmd_type_0, cmd_type_1;
    logic [PARA-1:0] proc_rel_time_0, proc_rel_time_1;
    logic [PARA-1:0] proc_ext_time_0, proc_ext_time_1;
    logic [PARA-1:0] event_proc_0, event_proc_1;
    logic            flush;
    logic [1:0]      gnt, done;
    logic            abort, err, busy, cur_id, ckg_en;
    logic [PARA-1:0] remaining;

    int n_vec = 0;
    int n_err = 0;

    proc_wait_sched #(.PARA(PARA)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .cmd_type_0      (cmd_type_0),
        .cmd_type_1      (cmd_type_1),
        .proc_rel_time_0 (proc_rel_time_0),
        .proc_rel_time_1 (proc_rel_time_1),
        .proc_ext_time_0 (proc_ext_time_0),
        .proc_ext_time_1 (proc_ext_time_1),
        .event_proc_0    (event_proc_0),
        .event_proc_1    (event_proc_1),
        .flush           (flush),
        .gnt             (gnt),
        .done            (done),
        .abort           (abort),
        .err             (err),
        .busy            (busy),
        .cur_id          (cur_id),
        .remaining       (remaining),
        .ckg_en          (ckg_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = 2'b00;
        flush = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; flush = 1'b0;
        cmd_type_0 = 5'd0; cmd_type_1 = 5'd0;
        proc_rel_time_0 = '0; proc_rel_time_1 = '0;
        proc_ext_time_0 = '0; proc_ext_time_1 = '0;
        event_proc_0 = 8'd7; event_proc_1 = 8'd7;

        // Reset values
        tick(); tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_abort", 32'(abort), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ckg", 32'(ckg_en), 32'h1);
        chk("rst_rem", 32'(remaining), 32'h0);
        chk("rst_id", 32'(cur_id), 32'h0);
        rst = 1'b0;

        // Relative wait of 3 on process 0
        do_reset();
        req = 2'b01; cmd_type_0 = 5'd1; proc_rel_time_0 = 8'd3;
        tick();
        chk("rel_gnt", 32'(gnt), 32'h1);
        chk("rel_rem1", 32'(remaining), 32'd3);
        chk("rel_ckg1", 32'(ckg_en), 32'h0);
        chk("rel_busy1", 32'(busy), 32'h1);
        req = 2'b00;
        tick();
        chk("rel_rem2", 32'(remaining), 32'd2);
        chk("rel_gnt_once", 32'(gnt), 32'h0);
        tick();
        chk("rel_rem3", 32'(remaining), 32'd1);
        chk("rel_ckg3", 32'(ckg_en), 32'h0);
        chk("rel_nodone3", 32'(done), 32'h0);
        tick();
        chk("rel_done4", 32'(done), 32'h1);
        chk("rel_rem4", 32'(remaining), 32'd0);
        chk("rel_ckg4", 32'(ckg_en), 32'h1);
        chk("rel_busy4", 32'(busy), 32'h1);
        tick();
        chk("rel_idle5", 32'(busy), 32'h0);
        chk("rel_done5", 32'(done), 32'h0);

        // Contention, round robin, external time
        do_reset();
        req = 2'b11; cmd_type_0 = 5'd2; cmd_type_1 = 5'd2;
        proc_ext_time_0 = 8'd2; proc_ext_time_1 = 8'd2;
        tick();
        chk("rr_gnt1", 32'(gnt), 32'h1);
        chk("rr_id1", 32'(cur_id), 32'h0);
        req = 2'b10;
        tick();
        tick();
        chk("rr_done3", 32'(done), 32'h1);
        tick();
        chk("rr_gnt4", 32'(gnt), 32'h0);
        chk("rr_busy4", 32'(busy), 32'h0);
        chk("rr_id_hold4", 32'(cur_id), 32'h0);
        tick();
        chk("rr_gnt5", 32'(gnt), 32'h2);
        chk("rr_id5", 32'(cur_id), 32'h1);
        req = 2'b00;
        tick();
        tick();
        chk("rr_done7", 32'(done), 32'h2);
        tick();
        req = 2'b11;
        tick();
        chk("rr_gnt_again", 32'(gnt), 32'h1);
        req = 2'b00;
        tick(); tick(); tick();

        // Event reference with one cycle of register latency
        do_reset();
        event_proc_0 = 8'd4; event_proc_1 = 8'd5;
        tick(); tick();
        req = 2'b10; cmd_type_1 = 5'd3;
        tick();
        chk("ev_gnt", 32'(gnt), 32'h2);
        chk("ev_rem", 32'(remaining), 32'd5);
        req = 2'b00;
        for (int i = 0; i < 4; i++) tick();
        chk("ev_nodone", 32'(done), 32'h0);
        tick();
        chk("ev_done", 32'(done), 32'h2);
        tick();
        event_proc_0 = 8'd9; req = 2'b01; cmd_type_0 = 5'd3;
        tick();
        chk("ev_latency", 32'(remaining), 32'd4);
        req = 2'b00;
        for (int i = 0; i < 4; i++) tick();
        chk("ev_done0", 32'(done), 32'h1);
        tick();

        // Illegal command
        do_reset();
        req = 2'b01; cmd_type_0 = 5'd7;
        tick();
        chk("ill_gnt", 32'(gnt), 32'h1);
        chk("ill_err", 32'(err), 32'h1);
        chk("ill_done", 32'(done), 32'h1);
        chk("ill_busy", 32'(busy), 32'h1);
        req = 2'b00;
        tick();
        chk("ill_busy2", 32'(busy), 32'h0);
        chk("ill_err2", 32'(err), 32'h0);

        // Flush mid-count
        do_reset();
        req = 2'b01; cmd_type_0 = 5'd1; proc_rel_time_0 = 8'd10;
        tick();
        req = 2'b00;
        tick(); tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_abort", 32'(abort), 32'h1);
        chk("fl_busy", 32'(busy), 32'h0);
        chk("fl_rem", 32'(remaining), 32'd0);
        chk("fl_done", 32'(done), 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("fl_nodone", 32'(done), 32'h0);
        end
        chk("fl_abort_once", 32'(abort), 32'h0);

        // Reset mid-count
        do_reset();
        req = 2'b01;
        tick();
        req = 2'b00;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rc_abort", 32'(abort), 32'h0);
        chk("rc_busy", 32'(busy), 32'h0);
        chk("rc_rem", 32'(remaining), 32'd0);
        chk("rc_ckg", 32'(ckg_en), 32'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rc_quiet", 32'({done, abort}), 32'h0);
        end

        // Flush wins over expiry
        do_reset();
        req = 2'b01; cmd_type_0 = 5'd1; proc_rel_time_0 = 8'd2;
        tick();
        req = 2'b00;
        tick();
        chk("fp_rem1", 32'(remaining), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fp_abort", 32'(abort), 32'h1);
        chk("fp_done", 32'(done), 32'h0);
        chk("fp_busy", 32'(busy), 32'h0);

        // Flush in IDLE does nothing
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fi_abort", 32'(abort), 32'h0);
        chk("fi_busy", 32'(busy), 32'h0);

        // Zero wait time
        do_reset();
        req = 2'b01; cmd_type_0 = 5'd1; proc_rel_time_0 = 8'd0;
        tick();
        chk("z_gnt", 32'(gnt), 32'h1);
        chk("z_done", 32'(done), 32'h1);
        chk("z_err", 32'(err), 32'h0);
        chk("z_rem", 32'(remaining), 32'd0);
        req = 2'b00;
        tick();
        chk("z_idle", 32'(busy), 32'h0);

        // Maximum wait time
        do_reset();
        req = 2'b01; cmd_type_0 = 5'd2; proc_ext_time_0 = 8'd255;
        tick();
        chk("max_rem", 32'(remaining), 32'd255);
        req = 2'b00;
        for (int i = 0; i < 254; i++) tick();
        chk("max_rem1", 32'(remaining), 32'd1);
        chk("max_nodone", 32'(done), 32'h0);
        tick();
        chk("max_done", 32'(done), 32'h1);
        chk("max_rem0", 32'(remaining), 32'd0);
        tick();
        chk("max_idle", 32'(busy), 32'h0);
        chk("max_nowrap", 32'(remaining), 32'd0);

        // Request held through reset is arbitrated right after it
        rst = 1'b1; req = 2'b11; cmd_type_0 = 5'd1; proc_rel_time_0 = 8'd1;
        tick(); tick();
        chk("rr_rst_gnt", 32'(gnt), 32'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        tick();
        chk("post_rst_done", 32'(done), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
